wnd_bmap_track: RTL and testbench
=================================

# wnd_bmap_track

Window bitmap tracker that sits directly upstream of the `cnt_set` popcount tree in the `cnt_wnd` path. It holds a sliding receive/ack bitmap and a window base sequence number. It applies per-packet mark and window-advance updates every cycle and drives the registered bitmap into `cnt_set`. It returns a snapshot count of set bits through a query/response handshake.

## Interface
- `VECT_WIDTH`, 64: window size in bits; bit 0 is the window head.
- `VECT_IND_WIDTH`, 7: index/count width; must hold the value `VECT_WIDTH`.
- `SEQ_WIDTH`, 32: window base sequence number width.

Ports:
- `clk` in 1: single clock; all state is on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `mark_valid` in 1: set one bit this cycle.
- `mark_idx` in `VECT_IND_WIDTH`: bit offset of the mark, relative to the post-advance head.
- `adv_valid` in 1: advance the window this cycle.
- `adv_cnt` in `VECT_IND_WIDTH`: number of bits to retire from the head.
- `q_valid` in 1: count query request.
- `q_ready` out 1: the FSM can accept a query.
- `resp_valid` out 1: `resp_cnt` is valid.
- `resp_ready` in 1: consumer accepts the response.
- `resp_cnt` out `VECT_IND_WIDTH`: snapshot popcount.
- `vect_out` out `VECT_WIDTH`: registered bitmap, driven to `cnt_set.vect_in`.
- `cnt_in` in `VECT_IND_WIDTH`: combinational popcount of `vect_out`, from `cnt_set.cnt_out`.
- `base_seq` out `SEQ_WIDTH`: sequence number of bit 0.
- `mark_err` out 1: registered one-cycle pulse on an out-of-window mark.

## Operation
- Bitmap update is applied every edge, regardless of FSM state.
  - Step 1: `shifted = adv_valid ? (bitmap >> adv_cnt) : bitmap`. Zeros fill from the MSB.
  - If `adv_cnt >= VECT_WIDTH`, then `shifted = 0`.
  - Step 2: if `mark_valid && mark_idx < VECT_WIDTH`, set bit `mark_idx` of `shifted`. Otherwise leave it unchanged.
  - Step 3: `bitmap <= shifted`.
- Marking an already-set bit is a no-op.
- A mark and an advance in the same cycle: the advance goes first, then the mark, with the index relative to the new head.
- `adv_valid` with `adv_cnt == 0` is a no-op and does not change `base_seq`.
- `base_seq <= base_seq + adv_cnt` (mod 2^`SEQ_WIDTH`) when `adv_valid`.
  - The add is never clamped, even when `adv_cnt > VECT_WIDTH`.
  - It wraps silently from 0xFFFFFFFF.
- `mark_err <= mark_valid && mark_idx >= VECT_WIDTH`. The bitmap is unchanged on an error.
- Query FSM, states IDLE, WAIT, RESP:
  - IDLE: `q_ready=1`. On `q_valid`, go to WAIT.
  - WAIT: always exactly one cycle. At its closing edge, `resp_cnt <= cnt_in`, then go to RESP.
  - RESP: `resp_valid=1` and `resp_cnt` is held stable. On `resp_ready`, go to IDLE.
  - `q_ready=0` in WAIT and RESP. There is no query pipelining.
- Snapshot semantics: `resp_cnt` equals the popcount of the bitmap after every update sampled at or before the query-accept edge. Updates at later edges are excluded.
- Reset values:
  - bitmap=0, `vect_out`=0
  - `base_seq`=0
  - `mark_err`=0
  - state=IDLE, so `q_ready`=1
  - `resp_valid`=0, `resp_cnt`=0
- Reset asserted mid-query returns the FSM to IDLE immediately and drops `resp_valid`. The pending response is lost.

## Timing
- Update latency: an update sampled at edge t is visible on `vect_out` after edge t.
- The count reflects it combinationally in the cycle after edge t, after `cnt_set` settles.
- Query latency: accept at edge t (`q_valid && q_ready`), then WAIT during cycle t..t+1. `resp_valid` rises after edge t+1, so a response takes a minimum of 2 cycles.
- Back-to-back throughput: one query per 3 cycles when `resp_ready` is held at 1.
- `cnt_in` has a full cycle to settle from `vect_out` to the capture edge. `cnt_set` must close timing at `VECT_WIDTH` in one cycle.
- `mark_err` is high for exactly one cycle, the cycle after the offending edge.
- `resp_valid` and `resp_cnt` are stable while `resp_ready=0`.

## Test plan
- Reset, then marks at idx 0, 5, 63 on consecutive cycles, then a query.
  - Required: `resp_cnt=3`, `resp_valid` 2 cycles after accept, `vect_out=0x8000_0000_0000_0021`.
- Bitmap = 0x0F. Same cycle: `adv_cnt=2` and mark idx 62.
  - Required: `vect_out=0x4000_0000_0000_0003`, `base_seq` +2, a following query returns 3.
- Query accepted at edge t while marks arrive at edges t+1 and t+2.
  - Required: `resp_cnt` excludes both marks; a second query includes them.
- `base_seq`=0xFFFF_FFFE, then `adv_cnt=64` with bitmap all ones.
  - Required: `base_seq`=0x0000_003E, `vect_out`=0, query returns 0.
- Mark with idx 64.
  - Required: `mark_err` pulses 1 cycle, bitmap unchanged. Also test a mark of an already-set bit: count unchanged.
- Hold `resp_ready=0` for 5 cycles while issuing marks, then assert `rst` mid-RESP.
  - Required: `resp_cnt` holds during backpressure; reset gives `resp_valid=0`, `q_ready=1`, `vect_out=0`, `base_seq=0`.

Source files
------------

// File: rtl/wnd_bmap_track.sv
// Sliding receive/ack window bitmap with base sequence number, feeding an
// external popcount tree, plus a query/response FSM that snapshots the count.
module wnd_bmap_track #(
  parameter int VECT_WIDTH     = 64,
  parameter int VECT_IND_WIDTH = 7,
  parameter int SEQ_WIDTH      = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      mark_valid,
  input  logic [VECT_IND_WIDTH-1:0] mark_idx,
  input  logic                      adv_valid,
  input  logic [VECT_IND_WIDTH-1:0] adv_cnt,
  input  logic                      q_valid,
  output logic                      q_ready,
  output logic                      resp_valid,
  input  logic                      resp_ready,
  output logic [VECT_IND_WIDTH-1:0] resp_cnt,
  output logic [VECT_WIDTH-1:0]     vect_out,
  input  logic [VECT_IND_WIDTH-1:0] cnt_in,
  output logic [SEQ_WIDTH-1:0]      base_seq,
  output logic                      mark_err
);

  localparam logic [VECT_IND_WIDTH-1:0] WIDTH_L = VECT_IND_WIDTH'(VECT_WIDTH);
  localparam logic [VECT_WIDTH-1:0]     ONE_L   = {{(VECT_WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  logic [VECT_WIDTH-1:0]     bitmap_r;
  logic [VECT_WIDTH-1:0]     shifted_s;
  logic [VECT_WIDTH-1:0]     next_bitmap_s;
  logic [SEQ_WIDTH-1:0]      base_seq_r;
  logic [SEQ_WIDTH-1:0]      next_seq_s;
  logic                      mark_ok_s;
  logic                      mark_bad_s;
  logic                      mark_err_r;
  logic                      q_ready_r;
  logic                      resp_valid_r;
  logic [VECT_IND_WIDTH-1:0] resp_cnt_r;
  state_t                    state_r;
  state_t                    state_s;

  assign mark_ok_s  = mark_valid && (mark_idx < WIDTH_L);
  assign mark_bad_s = mark_valid && (mark_idx >= WIDTH_L);

  // Window update: advance first, then mark relative to the new head.
  always_comb begin
    shifted_s     = bitmap_r;
    next_bitmap_s = bitmap_r;
    next_seq_s    = base_seq_r;
    if (adv_valid) begin
      // Sequence add is deliberately unclamped; only the bitmap saturates.
      next_seq_s = base_seq_r + {{(SEQ_WIDTH-VECT_IND_WIDTH){1'b0}}, adv_cnt};
      if (adv_cnt >= WIDTH_L) begin
        shifted_s = '0;
      end else begin
        shifted_s = bitmap_r >> adv_cnt;
      end
    end else begin
      shifted_s  = bitmap_r;
      next_seq_s = base_seq_r;
    end
    if (mark_ok_s) begin
      next_bitmap_s = shifted_s | (ONE_L << mark_idx);
    end else begin
      next_bitmap_s = shifted_s;
    end
  end

  // Window state registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bitmap_r   <= '0;
      base_seq_r <= '0;
      mark_err_r <= 1'b0;
    end else begin
      bitmap_r   <= next_bitmap_s;
      base_seq_r <= next_seq_s;
      mark_err_r <= mark_bad_s;
    end
  end

  // Query FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (q_valid) begin
          state_s = ST_WAIT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: state_s = ST_RESP;
      ST_RESP: begin
        if (resp_ready) begin
          state_s = ST_IDLE;
        end else begin
          state_s = ST_RESP;
        end
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // Query FSM state and registered handshake outputs; count captured as WAIT closes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      q_ready_r    <= 1'b1;
      resp_valid_r <= 1'b0;
      resp_cnt_r   <= '0;
    end else begin
      state_r      <= state_s;
      q_ready_r    <= (state_s == ST_IDLE);
      resp_valid_r <= (state_s == ST_RESP);
      if (state_r == ST_WAIT) begin
        resp_cnt_r <= cnt_in;
      end else begin
        resp_cnt_r <= resp_cnt_r;
      end
    end
  end

  assign vect_out   = bitmap_r;
  assign base_seq   = base_seq_r;
  assign mark_err   = mark_err_r;
  assign q_ready    = q_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_cnt   = resp_cnt_r;

endmodule

// File: tb/tb_wnd_bmap_track.sv
// Directed self-checking bench for wnd_bmap_track; models cnt_set as a popcount
// and uses a narrow-sequence second instance to exercise base_seq wraparound.
module tb_wnd_bmap_track;

  logic        clk;
  logic        rst;
  logic        mark_valid;
  logic [6:0]  mark_idx;
  logic        adv_valid;
  logic [6:0]  adv_cnt;
  logic        q_valid;
  logic        q_ready;
  logic        resp_valid;
  logic        resp_ready;
  logic [6:0]  resp_cnt;
  logic [63:0] vect_out;
  logic [6:0]  cnt_in;
  logic [31:0] base_seq;
  logic        mark_err;

  logic        w_q_ready;
  logic        w_resp_valid;
  logic [6:0]  w_resp_cnt;
  logic [63:0] w_vect_out;
  logic [6:0]  w_cnt_in;
  logic [7:0]  w_base_seq;
  logic        w_mark_err;

  int errors = 0;
  int checks = 0;

  wnd_bmap_track dut (
    .clk(clk), .rst(rst), .mark_valid(mark_valid), .mark_idx(mark_idx),
    .adv_valid(adv_valid), .adv_cnt(adv_cnt), .q_valid(q_valid), .q_ready(q_ready),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_cnt(resp_cnt),
    .vect_out(vect_out), .cnt_in(cnt_in), .base_seq(base_seq), .mark_err(mark_err)
  );

  wnd_bmap_track #(.SEQ_WIDTH(8)) dut_w (
    .clk(clk), .rst(rst), .mark_valid(mark_valid), .mark_idx(mark_idx),
    .adv_valid(adv_valid), .adv_cnt(adv_cnt), .q_valid(1'b0), .q_ready(w_q_ready),
    .resp_valid(w_resp_valid), .resp_ready(1'b0), .resp_cnt(w_resp_cnt),
    .vect_out(w_vect_out), .cnt_in(w_cnt_in), .base_seq(w_base_seq), .mark_err(w_mark_err)
  );

  assign cnt_in   = 7'($countones(vect_out));
  assign w_cnt_in = 7'($countones(w_vect_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    mark_valid = 1'b0; mark_idx = 7'd0; adv_valid = 1'b0; adv_cnt = 7'd0;
    q_valid = 1'b0; resp_ready = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic mark(input logic [6:0] idx);
    mark_valid = 1'b1; mark_idx = idx;
    tick();
    mark_valid = 1'b0; mark_idx = 7'd0;
  endtask

  // Issues one query with resp_ready high; cyc = edges from accept to resp_valid (0 on timeout).
  task automatic run_query(output logic [6:0] cnt, output int cyc);
    cnt = 7'd0; cyc = 0;
    q_valid = 1'b1; resp_ready = 1'b1;
    tick();
    q_valid = 1'b0;
    cyc = 1;
    for (int i = 0; i < 8 && !resp_valid; i++) begin
      tick();
      cyc++;
    end
    if (resp_valid) begin
      cnt = resp_cnt;
      tick();
    end else begin
      cyc = 0;
    end
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b1;
    #1;
    checks++; if (vect_out !== 64'h0) begin errors++; $display("FAIL reset_vect: got %h want 0", vect_out); end
    checks++; if (base_seq !== 32'h0) begin errors++; $display("FAIL reset_base: got %h want 0", base_seq); end
    checks++; if (mark_err !== 1'b0) begin errors++; $display("FAIL reset_mark_err: got %b want 0", mark_err); end
    checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL reset_q_ready: got %b want 1", q_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL reset_resp_valid: got %b want 0", resp_valid); end
    checks++; if (resp_cnt !== 7'd0) begin errors++; $display("FAIL reset_resp_cnt: got %0d want 0", resp_cnt); end
    checks++;
    if ({w_q_ready, w_resp_valid, w_resp_cnt, w_mark_err, w_base_seq} !== {1'b1, 1'b0, 7'd0, 1'b0, 8'h00}) begin
      errors++; $display("FAIL reset_narrow: got %b%b %0d %b %h want 1 0 0 0 00",
                         w_q_ready, w_resp_valid, w_resp_cnt, w_mark_err, w_base_seq);
    end
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_marks();
    logic [6:0] cnt; int cyc;
    mark(7'd0); mark(7'd5); mark(7'd63);
    checks++; if (vect_out !== 64'h8000_0000_0000_0021) begin errors++; $display("FAIL marks_vect: got %h want 8000000000000021", vect_out); end
    run_query(cnt, cyc);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL marks_latency: got %0d want 2", cyc); end
    checks++; if (cnt !== 7'd3) begin errors++; $display("FAIL marks_count: got %0d want 3", cnt); end
    checks++; if (q_ready !== 1'b1) begin errors++; $display("FAIL marks_q_ready_after: got %b want 1", q_ready); end
  endtask

  task automatic test_adv_mark();
    logic [6:0] cnt; int cyc;
    do_reset();
    mark(7'd0); mark(7'd1); mark(7'd2); mark(7'd3);
    checks++; if (vect_out !== 64'h0F) begin errors++; $display("FAIL advmark_pre: got %h want f", vect_out); end
    adv_valid = 1'b1; adv_cnt = 7'd2; mark_valid = 1'b1; mark_idx = 7'd62;
    tick();
    idle_inputs();
    checks++; if (vect_out !== 64'h4000_0000_0000_0003) begin errors++; $display("FAIL advmark_vect: got %h want 4000000000000003", vect_out); end
    checks++; if (base_seq !== 32'd2) begin errors++; $display("FAIL advmark_base: got %h want 2", base_seq); end
    run_query(cnt, cyc);
    checks++; if (cnt !== 7'd3 || cyc !== 2) begin errors++; $display("FAIL advmark_query: got %0d/%0d want 3/2", cnt, cyc); end
  endtask

  task automatic test_snapshot();
    logic [6:0] cnt; int cyc;
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
    checks++; if (q_ready !== 1'b0) begin errors++; $display("FAIL snap_wait_q_ready: got %b want 0", q_ready); end
    mark_valid = 1'b1; mark_idx = 7'd10;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_cnt !== 7'd3) begin errors++; $display("FAIL snap_first: got v=%b cnt=%0d want v=1 cnt=3", resp_valid, resp_cnt); end
    mark_idx = 7'd11; resp_ready = 1'b1;
    tick();
    idle_inputs();
    checks++; if (resp_valid !== 1'b0 || q_ready !== 1'b1) begin errors++; $display("FAIL snap_release: got v=%b qr=%b want 0 1", resp_valid, q_ready); end
    run_query(cnt, cyc);
    checks++; if (cnt !== 7'd5) begin errors++; $display("FAIL snap_second: got %0d want 5", cnt); end
  endtask

  task automatic test_wrap();
    logic [6:0] cnt; int cyc;
    do_reset();
    adv_valid = 1'b1; adv_cnt = 7'd127;
    tick(); tick();
    idle_inputs();
    checks++; if (base_seq !== 32'hFE || w_base_seq !== 8'hFE) begin errors++; $display("FAIL wrap_pre_base: got %h/%h want fe/fe", base_seq, w_base_seq); end
    for (int i = 0; i < 64; i++) mark(7'(i));
    checks++; if (vect_out !== 64'hFFFF_FFFF_FFFF_FFFF || w_vect_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_full: got %h/%h want all ones", vect_out, w_vect_out); end
    adv_valid = 1'b1; adv_cnt = 7'd0;
    tick();
    checks++; if (base_seq !== 32'hFE || vect_out !== 64'hFFFF_FFFF_FFFF_FFFF) begin errors++; $display("FAIL wrap_adv0: got %h %h want fe all ones", base_seq, vect_out); end
    adv_cnt = 7'd64;
    tick();
    idle_inputs();
    checks++; if (w_base_seq !== 8'h3E) begin errors++; $display("FAIL wrap_narrow_base: got %h want 3e", w_base_seq); end
    checks++; if (base_seq !== 32'h13E) begin errors++; $display("FAIL wrap_base: got %h want 13e", base_seq); end
    checks++; if (vect_out !== 64'h0) begin errors++; $display("FAIL wrap_vect: got %h want 0", vect_out); end
    run_query(cnt, cyc);
    checks++; if (cnt !== 7'd0 || cyc !== 2) begin errors++; $display("FAIL wrap_query: got %0d/%0d want 0/2", cnt, cyc); end
  endtask

  task automatic test_mark_err();
    logic [6:0] cnt; int cyc;
    mark(7'd7);
    checks++; if (mark_err !== 1'b0) begin errors++; $display("FAIL err_quiet: got %b want 0", mark_err); end
    mark(7'd64);
    checks++; if (mark_err !== 1'b1) begin errors++; $display("FAIL err_pulse: got %b want 1", mark_err); end
    checks++; if (vect_out !== 64'h80) begin errors++; $display("FAIL err_vect: got %h want 80", vect_out); end
    tick();
    checks++; if (mark_err !== 1'b0) begin errors++; $display("FAIL err_width: got %b want 0", mark_err); end
    mark(7'd7);
    checks++; if (vect_out !== 64'h80) begin errors++; $display("FAIL dup_vect: got %h want 80", vect_out); end
    run_query(cnt, cyc);
    checks++; if (cnt !== 7'd1) begin errors++; $display("FAIL dup_count: got %0d want 1", cnt); end
  endtask

  task automatic test_backpressure();
    q_valid = 1'b1;
    tick();
    q_valid = 1'b0;
    tick();
    checks++; if (resp_valid !== 1'b1 || resp_cnt !== 7'd1) begin errors++; $display("FAIL bp_resp: got v=%b cnt=%0d want 1 1", resp_valid, resp_cnt); end
    for (int i = 0; i < 5; i++) begin
      mark(7'(20 + i));
      checks++;
      if (resp_valid !== 1'b1 || resp_cnt !== 7'd1) begin errors++; $display("FAIL bp_hold%0d: got v=%b cnt=%0d want 1 1", i, resp_valid, resp_cnt); end
    end
    checks++; if (vect_out !== 64'h1F0_0080) begin errors++; $display("FAIL bp_vect: got %h want 1f00080", vect_out); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (resp_valid !== 1'b0 || q_ready !== 1'b1) begin errors++; $display("FAIL rst_fsm: got v=%b qr=%b want 0 1", resp_valid, q_ready); end
    checks++; if (vect_out !== 64'h0 || base_seq !== 32'h0 || resp_cnt !== 7'd0) begin errors++; $display("FAIL rst_state: got %h %h %0d want 0 0 0", vect_out, base_seq, resp_cnt); end
    tick();
    rst = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_marks();
    test_adv_mark();
    test_snapshot();
    test_wrap();
    test_mark_err();
    test_backpressure();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
